// File: rtl/program_loader_pkg.sv
// ----------------------------------------------------------------------------
// program_loader_pkg
// Shared types and constants for the program loader.
//   loader_state_t     : loader FSM states
//   LOADER_WORD_BYTES  : bytes per instruction word
//   is_legal_count()   : word-count byte range check
//   state_accepts()    : whether a state offers in_ready
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds the CHECK state.
// ----------------------------------------------------------------------------
package program_loader_pkg;

    localparam int LOADER_WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    // A count of zero or beyond the memory depth can never be loaded.
    function automatic logic is_legal_count(input logic [7:0] n, input int unsigned depth);
        return (n != 8'd0) && (32'(n) <= depth);
    endfunction

    function automatic logic state_accepts(input loader_state_t s);
        logic r;
        r = 1'b0;
        case (s)
            ST_IDLE:  r = 1'b1;
            ST_LOAD:  r = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CHECK: r = 1'b1;
`endif
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// ----------------------------------------------------------------------------
// program_loader_if
// Byte-stream input handshake plus instruction-memory write bus and CPU
// control outputs of the program loader.
//   in_valid/in_data/in_ready : byte stream; a byte moves on a rising edge
//                               where in_valid && in_ready (in_ready does not
//                               depend on in_valid; in_valid may be dropped at
//                               any time)
//   imem_we/imem_addr/imem_wdata : one-cycle word write strobe
//   cpu_reset/done/error      : CPU hold-reset and load status
// Modports: slave = loader side, master = stream source / memory side.
// ----------------------------------------------------------------------------
interface program_loader_if #(
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
    );
endinterface

// File: rtl/program_loader_byte_assembler.sv
// ----------------------------------------------------------------------------
// program_loader_byte_assembler (byte assembler)
// Packs accepted bytes little-endian into a 32-bit word.
//   clk, reset     : clock, synchronous active-high reset
//   i_clear        : restart assembly at byte 0 with an empty word
//   i_byte_valid   : a byte is accepted this cycle
//   i_byte         : the accepted byte
//   o_word_valid   : this byte completes the word (combinational)
//   o_word         : current word with the incoming byte inserted
// ----------------------------------------------------------------------------
module program_loader_byte_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);
    localparam int BYTE_CNT_W = $clog2(LOADER_WORD_BYTES);
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(LOADER_WORD_BYTES - 1);

    logic [BYTE_CNT_W-1:0] r_byte_cnt;
    logic [31:0]           r_word;
    logic [31:0]           w_word;
    logic                  w_last;

    assign w_last = (r_byte_cnt == LAST_BYTE);

    // Byte k lands at bits [8k+7:8k].
    always_comb begin
        w_word = r_word;
        w_word[{r_byte_cnt, 3'b000} +: 8] = i_byte;
    end

    assign o_word_valid = i_byte_valid && w_last;
    assign o_word       = w_word;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_byte_cnt <= '0;
            r_word     <= '0;
        end else if (i_byte_valid) begin
            if (w_last) begin
                // Word handed off this edge; start the next one empty.
                r_byte_cnt <= '0;
                r_word     <= '0;
            end else begin
                r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
                r_word     <= w_word;
            end
        end
    end
endmodule

// File: rtl/program_loader.sv
// ----------------------------------------------------------------------------
// program_loader
// Receives a byte stream (count byte N, then N little-endian 32-bit words,
// then optionally an XOR checksum byte), writes the words to instruction
// memory and releases the CPU from reset once the load succeeds.
//   clk, reset : clock, synchronous active-high reset
//   bus        : program_loader_if.slave (stream in, imem write, status)
//   o_state    : current FSM state, for observation
// Parameters: DEPTH (memory words), ADDR_W (= log2(DEPTH)).
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (trailing XOR byte).
// ----------------------------------------------------------------------------
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    program_loader_if.slave         bus,
    output loader_state_t           o_state
);
    loader_state_t     r_state;
    loader_state_t     w_next_state;
    logic              r_in_ready;
    logic              r_cpu_reset;
    logic              r_done;
    logic              r_error;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_imem_wdata;
    logic [ADDR_W-1:0] r_word_idx;
    // N-1 is held rather than N so the last-word test is a plain compare.
    logic [ADDR_W-1:0] r_last_idx;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]        r_xor;
`endif

    logic              w_accept;
    logic              w_start;
    logic              w_load_byte;
    logic              w_word_valid;
    logic [31:0]       w_word;

    assign w_accept    = bus.in_valid && r_in_ready;
    assign w_start     = w_accept && (r_state == ST_IDLE) &&
                         is_legal_count(bus.in_data, DEPTH);
    assign w_load_byte = w_accept && (r_state == ST_LOAD);

    program_loader_byte_assembler u_byte_assembler (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_start),
        .i_byte_valid (w_load_byte),
        .i_byte       (bus.in_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_start ? ST_LOAD : ST_ERROR;
                end
            end
            ST_LOAD: begin
                if (w_word_valid && (r_word_idx == r_last_idx)) begin
                    w_next_state = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                w_next_state = ST_CHECK;
`else
                w_next_state = ST_DONE;
`endif
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (w_accept) begin
                    w_next_state = (bus.in_data == r_xor) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            ST_DONE:  w_next_state = ST_DONE;
            ST_ERROR: w_next_state = ST_ERROR;
            default:  w_next_state = ST_ERROR;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // exactly with r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b1;
            r_cpu_reset  <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_word_idx   <= '0;
            r_last_idx   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_xor        <= '0;
`endif
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= state_accepts(w_next_state);
            r_cpu_reset <= (w_next_state != ST_DONE);
            r_done      <= (w_next_state == ST_DONE);
            r_error     <= (w_next_state == ST_ERROR);
            r_imem_we   <= w_word_valid;
            if (w_word_valid) begin
                r_imem_addr  <= r_word_idx;
                r_imem_wdata <= w_word;
                r_word_idx   <= r_word_idx + ADDR_W'(1);
            end
            if (w_start) begin
                r_word_idx <= '0;
                r_last_idx <= ADDR_W'(bus.in_data - 8'd1);
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            // The count byte seeds the running XOR.
            if (w_start) begin
                r_xor <= bus.in_data;
            end else if (w_load_byte) begin
                r_xor <= r_xor ^ bus.in_data;
            end
`endif
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign bus.cpu_reset  = r_cpu_reset;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
    assign o_state        = r_state;
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DEPTH, default 32: instruction-memory depth in 32-bit words.
REQ-002 Parameter ADDR_W, default 5: word-address width, equal to log2(DEPTH).
REQ-003 clk  input  1: rising-edge clock.
REQ-004 reset  input  1: reset, synchronous, active-high; clock clk.
REQ-005 in_valid  input  1: a byte is offered on in_data.
REQ-006 in_data  input  8: program byte stream.
REQ-007 in_ready  output  1: the loader accepts a byte; transfer occurs when in_valid && in_ready at a rising edge.
REQ-008 imem_we  output  1: one-cycle write strobe to instruction memory.
REQ-009 imem_addr  output  ADDR_W: word index being written.
REQ-010 imem_wdata  output  32: assembled instruction word.
REQ-011 cpu_reset  output  1: hold-reset for the CPU, active-high.
REQ-012 done  output  1: load completed successfully.
REQ-013 error  output  1: load failed; sticky until reset.

Function
REQ-014 States SHALL be IDLE, LOAD, COMMIT, CHECK (CHECKSUM_EN only), DONE and ERROR.
REQ-015 in_ready SHALL be 1 in IDLE, LOAD and CHECK, and 0 in COMMIT, DONE and ERROR.
REQ-016 IDLE: the first accepted byte SHALL be the word count N.
- N in 1..DEPTH: latch N, clear the word and byte counters, go to LOAD.
- N=0 or N>DEPTH: go to ERROR.
REQ-017 LOAD: each accepted byte SHALL be placed little-endian into the word being assembled, byte k (0..3) going to bits [8k+7:8k].
REQ-018 On the edge that accepts byte 3 of word w, the loader SHALL register imem_we=1, imem_addr=w and imem_wdata=the assembled word, giving one-cycle write latency.
REQ-019 imem_we SHALL be high for exactly one cycle per word, and SHALL never be high outside the cycle following a word completion.
REQ-020 When word N-1 completes, the state SHALL go to COMMIT; otherwise it stays in LOAD with w incremented.
REQ-021 COMMIT SHALL last exactly one cycle, then go to CHECK if CHECKSUM_EN is defined, else to DONE.
- This guarantees cpu_reset falls at least one cycle after the final imem_we.
REQ-022 cpu_reset SHALL be 1 in every state except DONE.
REQ-023 done SHALL equal (state==DONE); error SHALL equal (state==ERROR).
REQ-024 DONE and ERROR SHALL be exited only by reset.
REQ-025 Bytes offered while in_ready=0 SHALL be ignored without side effects.
REQ-026 A stall (in_valid=0) in any state SHALL hold all counters and the partial word unchanged.

Reset
REQ-027 While reset=1 at a rising edge: state=IDLE, all counters=0, partial word=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0.
REQ-028 Reset mid-load SHALL abandon the partial word with no further imem_we; instruction memory contents already written are not cleared.

Configuration
REQ-029 Macro PROGRAM_LOADER_CHECKSUM_EN SHALL control the checksum feature.
- Defined: the running XOR of all accepted bytes (count byte included) is kept. CHECK accepts one trailing byte; equal to the running XOR goes to DONE, else to ERROR.
- Undefined: no CHECK state and no XOR register; COMMIT goes directly to DONE, and ERROR is reachable only via an illegal count.

Structure
REQ-030 A shared package SHALL hold the loader_state_t enum and the constant LOADER_WORD_BYTES=4.
REQ-031 A sub-module byte_assembler SHALL hold the byte counter and the 32-bit shift/insert register; it reports word_valid and word.

Verification
REQ-032 Stream 01,13,00,00,00 -> one imem_we with addr 0, wdata 0x00000013; cpu_reset falls 2 cycles later; done=1.
REQ-033 Stream 02,93,00,50,00,13,01,A0,00 with in_valid toggling every cycle -> writes addr0=0x00500093 and addr1=0x00A00113, then done; counters hold during gaps.
REQ-034 Count byte 00, and separately 21 (33) -> error=1, in_ready=0, no imem_we, cpu_reset stays 1.
REQ-035 Reset asserted after 2 payload bytes, then full stream 01,EF,BE,AD,DE -> no write before the reset, a single write of 0xDEADBEEF to addr 0 after it.
REQ-036 CHECKSUM_EN: stream 01,13,00,00,00,12 -> done; same stream with trailer 00 -> error=1, cpu_reset=1.
REQ-037 Bytes presented after DONE -> in_ready=0, no imem_we, done stays 1.
